fixed_2d_tile_gather: RTL and testbench
=======================================

# fixed_2d_tile_gather

Downstream companion to `fixed_2d_linear`. It collects the `W_NUM_PARALLELISM` consecutive output tiles (each `IN_PARALLELISM × W_PARALLELISM`) that the linear stage emits for one row-block. Each element is requantised to the next layer's fixed-point format. The block then presents the full `IN_PARALLELISM × (W_PARALLELISM·W_NUM_PARALLELISM)` row-block as one beat, which is the `IN_SIZE`-wide input the following linear layer expects. Two ping-pong banks let one row-block drain while the next fills.

## Interface
Parameters:
- `IN_WIDTH`, 32: element width from the linear stage (signed).
- `IN_FRAC_WIDTH`, 8: input fractional bits.
- `OUT_WIDTH`, 8: output element width (signed).
- `OUT_FRAC_WIDTH`, 4: output fractional bits; must be ≤ `IN_FRAC_WIDTH`.
- `IN_PARALLELISM`, 2: rows per tile.
- `W_PARALLELISM`, 2: columns per tile.
- `W_NUM_PARALLELISM`, 3: tiles per row-block.
- `IN_NUM_PARALLELISM`, 2: row-blocks per matrix; drives `data_out_last`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `data_in`  in  `IN_WIDTH` × `IN_PARALLELISM·W_PARALLELISM`  tile; element `[r·W_PARALLELISM+c]`.
- `data_in_valid`  in  1.
- `data_in_ready`  out  1.
- `data_out`  out  `OUT_WIDTH` × `IN_PARALLELISM·ROW`  row-block, where `ROW = W_PARALLELISM·W_NUM_PARALLELISM`.
- `data_out_valid`  out  1.
- `data_out_ready`  in  1.
- `data_out_last`  out  1  high on the final row-block of a matrix.

## Operation
- Requantise each element on write:
  - Arithmetic right shift by `IN_FRAC_WIDTH−OUT_FRAC_WIDTH`. This truncates toward −∞.
  - Saturate to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1].
- Placement: tile index t (0…`W_NUM_PARALLELISM`−1), input element `[r·W_PARALLELISM+c]` → bank word `[r·ROW + t·W_PARALLELISM + c]`.
- Per-bank state is EMPTY → FILLING → FULL → EMPTY.
  - EMPTY→FILLING on the first tile accept.
  - FILLING→FULL on the accept of tile t = `W_NUM_PARALLELISM`−1.
  - FULL→EMPTY on the output handshake.
  - With `W_NUM_PARALLELISM` = 1, EMPTY→FULL directly.
- Registers:
  - `wr_sel` toggles on the last-tile accept.
  - Tile counter `t` wraps to 0 at the same time.
  - `rd_sel` toggles on the output handshake.
  - Row-block counter increments on the output handshake and wraps at `IN_NUM_PARALLELISM`−1.
- `data_in_ready` = bank[`wr_sel`] ≠ FULL. It is derived only from registered state, with no combinational path from `data_out_ready`.
- `data_out_valid` = bank[`rd_sel`] == FULL.
- `data_out` = storage of bank[`rd_sel`].
- `data_out_last` = (row-block counter == `IN_NUM_PARALLELISM`−1) && `data_out_valid`.
- A write into one bank and a read from the other in the same cycle proceed independently.

## Timing
- Reset (async assert, state cleared immediately):
  - all storage 0;
  - banks EMPTY;
  - `wr_sel`, `rd_sel`, `t` and the row-block counter all 0;
  - `data_out_valid` = 0, `data_out_last` = 0, `data_out` all 0;
  - `data_in_ready` = 1.
- Reset mid-operation discards partial and full banks. The row-block counter restarts at 0.
- Accept happens on `data_in_valid && data_in_ready` at the rising edge. The storage write occurs at that edge.
- Latency: `data_out_valid` rises 1 cycle after the last-tile accept.
- A bank freed by a handshake at edge N can accept a tile from the cycle after edge N. `data_in_ready` rises in that cycle.
- Both banks FULL → `data_in_ready` = 0. The upstream tile is held.
- Once `data_out_valid` is high, `data_out` and `data_out_last` stay stable until the handshake.
- With sustained `data_out_ready` = 1, the block accepts one tile per cycle indefinitely.

## Structure
- Shared package `fixed_tile_pkg` holds:
  - `bank_state_t` enum (EMPTY, FILLING, FULL);
  - a `sat_trunc` function parameterised by the widths, reused by other requantising stages.
- One sub-module, `tile_gather_bank`, contains one bank's storage, state register and tile write-enable decode. It is instantiated twice.
- The top level holds `wr_sel`, `rd_sel`, the tile counter, the row-block counter and the output mux.

## Test plan
All scenarios use default parameters.
- **Placement:** element value = (t·4 + r·2 + c)<<4 in Q.8. Send 3 tiles with `data_out_ready` = 1.
  - Required: one beat with `data_out[r·6+t·2+c]` = t·4 + r·2 + c.
  - Required: `data_out_valid` high 1 cycle after the 3rd accept; `data_out_last` = 0.
- **Saturation:** send 0x7FFFFFFF, 0x80000000, 0xFFFFFFFF, 0x0000000F.
  - Required outputs: 127, −128, −1, 0.
- **Backpressure:** hold `data_out_ready` = 0 and send 6 tiles.
  - Required: `data_in_ready` = 0 from the cycle after the 6th accept; the 7th tile is held unaccepted.
  - Then raise `data_out_ready` for one cycle. Required: first block out, `data_in_ready` = 1 the next cycle, second block valid.
- **Streaming:** `data_out_ready` = 1, 12 tiles back-to-back.
  - Required: `data_in_ready` never drops; 4 beats out; `data_out_last` = 1 on beats 2 and 4.
- **Reset mid-fill:** after 2 tiles, pulse `rst`.
  - Required: `data_out_valid` = 0, `data_in_ready` = 1 immediately.
  - Then send 3 new tiles. Required: the block contains only new data, `data_out_last` = 0.

Source files
------------

// File: rtl/fixed_tile_pkg.sv
// Shared types and requantisation helper for the fixed-point tile stages.
package fixed_tile_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

  // Widest element any requantising stage may feed through sat_trunc.
  localparam int SAT_MAX_W = 64;

  // Arithmetic right shift (floor toward -inf) followed by saturation to a signed outWidth range.
  function automatic logic signed [SAT_MAX_W-1:0] sat_trunc(
    input logic signed [SAT_MAX_W-1:0] x,
    input int                          shift,
    input int                          outWidth
  );
    logic signed [SAT_MAX_W-1:0] shifted;
    logic signed [SAT_MAX_W-1:0] hiLim;
    logic signed [SAT_MAX_W-1:0] loLim;
    shifted = x >>> shift;
    hiLim   = (64'sd1 <<< (outWidth - 1)) - 64'sd1;
    loLim   = -(64'sd1 <<< (outWidth - 1));
    if (shifted > hiLim) begin
      return hiLim;
    end else if (shifted < loLim) begin
      return loLim;
    end else begin
      return shifted;
    end
  endfunction

endpackage

// File: rtl/tile_gather_bank.sv
// One ping-pong bank: row-block storage, fill state and per-tile write decode.
module tile_gather_bank
  import fixed_tile_pkg::*;
#(
  parameter int OUT_WIDTH         = 8,
  parameter int IN_PARALLELISM    = 2,
  parameter int W_PARALLELISM     = 2,
  parameter int W_NUM_PARALLELISM = 3,
  parameter int TILE_W            = 2
) (
  input  logic                                                         clk,
  input  logic                                                         rst,
  input  logic                                                         wr_en_i,
  input  logic [TILE_W-1:0]                                            tile_idx_i,
  input  logic [IN_PARALLELISM*W_PARALLELISM-1:0][OUT_WIDTH-1:0]       tile_i,
  input  logic                                                         rd_ack_i,
  output bank_state_t                                                  state_o,
  output logic [IN_PARALLELISM*W_PARALLELISM*W_NUM_PARALLELISM-1:0][OUT_WIDTH-1:0] data_o
);

  localparam int ROW = W_PARALLELISM * W_NUM_PARALLELISM;
  localparam int BE  = IN_PARALLELISM * ROW;

  logic [BE-1:0][OUT_WIDTH-1:0] mem_q, mem_d;
  bank_state_t                  state_q, state_d;
  logic                         lastTile;

  assign lastTile = (tile_idx_i == TILE_W'(W_NUM_PARALLELISM - 1));

  // Scatter the incoming tile into its column slot of the row-block.
  always_comb begin
    mem_d = mem_q;
    if (wr_en_i) begin
      for (int t = 0; t < W_NUM_PARALLELISM; t++) begin
        if (tile_idx_i == TILE_W'(t)) begin
          for (int r = 0; r < IN_PARALLELISM; r++) begin
            for (int c = 0; c < W_PARALLELISM; c++) begin
              mem_d[r*ROW + t*W_PARALLELISM + c] = tile_i[r*W_PARALLELISM + c];
            end
          end
        end
      end
    end
  end

  // Bank lifecycle: filled by tile accepts, emptied by the output handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (wr_en_i) state_d = lastTile ? FULL : FILLING;
      FILLING: if (wr_en_i && lastTile) state_d = FULL;
      FULL:    if (rd_ack_i) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Storage and state registers, cleared immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q   <= '0;
      state_q <= EMPTY;
    end else begin
      mem_q   <= mem_d;
      state_q <= state_d;
    end
  end

  assign state_o = state_q;
  assign data_o  = mem_q;

endmodule

// File: rtl/fixed_2d_tile_gather.sv
// Gathers consecutive linear-stage tiles into one requantised row-block beat, double-buffered.
module fixed_2d_tile_gather
  import fixed_tile_pkg::*;
#(
  parameter int IN_WIDTH           = 32,
  parameter int IN_FRAC_WIDTH      = 8,
  parameter int OUT_WIDTH          = 8,
  parameter int OUT_FRAC_WIDTH     = 4,
  parameter int IN_PARALLELISM     = 2,
  parameter int W_PARALLELISM      = 2,
  parameter int W_NUM_PARALLELISM  = 3,
  parameter int IN_NUM_PARALLELISM = 2
) (
  input  logic                                                         clk,
  input  logic                                                         rst,
  input  logic [IN_PARALLELISM*W_PARALLELISM-1:0][IN_WIDTH-1:0]        data_in,
  input  logic                                                         data_in_valid,
  output logic                                                         data_in_ready,
  output logic [IN_PARALLELISM*W_PARALLELISM*W_NUM_PARALLELISM-1:0][OUT_WIDTH-1:0] data_out,
  output logic                                                         data_out_valid,
  input  logic                                                         data_out_ready,
  output logic                                                         data_out_last
);

  localparam int TE     = IN_PARALLELISM * W_PARALLELISM;
  localparam int BE     = TE * W_NUM_PARALLELISM;
  localparam int SHIFT  = IN_FRAC_WIDTH - OUT_FRAC_WIDTH;
  localparam int TILE_W = (W_NUM_PARALLELISM > 1) ? $clog2(W_NUM_PARALLELISM) : 1;
  localparam int RB_W   = (IN_NUM_PARALLELISM > 1) ? $clog2(IN_NUM_PARALLELISM) : 1;

  logic                         wrSel_q, wrSel_d;
  logic                         rdSel_q, rdSel_d;
  logic [TILE_W-1:0]            tile_q, tile_d;
  logic [RB_W-1:0]              rowBlk_q, rowBlk_d;
  logic                         accept, handshake, lastTile;
  logic [TE-1:0][OUT_WIDTH-1:0] quantTile;
  bank_state_t                  bankState [2];
  logic [BE-1:0][OUT_WIDTH-1:0] bankData  [2];

  assign data_in_ready  = (bankState[wrSel_q] != FULL);
  assign data_out_valid = (bankState[rdSel_q] == FULL);
  assign accept         = data_in_valid && data_in_ready;
  assign handshake      = data_out_valid && data_out_ready;
  assign lastTile       = (tile_q == TILE_W'(W_NUM_PARALLELISM - 1));
  assign data_out       = rdSel_q ? bankData[1] : bankData[0];
  assign data_out_last  = (rowBlk_q == RB_W'(IN_NUM_PARALLELISM - 1)) && data_out_valid;

  // Requantise every element of the incoming tile before it is stored.
  always_comb begin
    quantTile = '0;
    for (int e = 0; e < TE; e++) begin
      quantTile[e] = OUT_WIDTH'(sat_trunc(SAT_MAX_W'(signed'(data_in[e])), SHIFT, OUT_WIDTH));
    end
  end

  // Next-state for write/read bank selects, tile counter and row-block counter.
  always_comb begin
    wrSel_d  = wrSel_q;
    rdSel_d  = rdSel_q;
    tile_d   = tile_q;
    rowBlk_d = rowBlk_q;
    if (accept) begin
      if (lastTile) begin
        tile_d  = '0;
        wrSel_d = ~wrSel_q;
      end else begin
        tile_d = tile_q + TILE_W'(1);
      end
    end
    if (handshake) begin
      rdSel_d = ~rdSel_q;
      if (rowBlk_q == RB_W'(IN_NUM_PARALLELISM - 1)) begin
        rowBlk_d = '0;
      end else begin
        rowBlk_d = rowBlk_q + RB_W'(1);
      end
    end
  end

  // Control registers, all cleared on reset so partial fills are discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrSel_q  <= 1'b0;
      rdSel_q  <= 1'b0;
      tile_q   <= '0;
      rowBlk_q <= '0;
    end else begin
      wrSel_q  <= wrSel_d;
      rdSel_q  <= rdSel_d;
      tile_q   <= tile_d;
      rowBlk_q <= rowBlk_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    tile_gather_bank #(
      .OUT_WIDTH         (OUT_WIDTH),
      .IN_PARALLELISM    (IN_PARALLELISM),
      .W_PARALLELISM     (W_PARALLELISM),
      .W_NUM_PARALLELISM (W_NUM_PARALLELISM),
      .TILE_W            (TILE_W)
    ) u_bank (
      .clk        (clk),
      .rst        (rst),
      .wr_en_i    (accept && (wrSel_q == 1'(b))),
      .tile_idx_i (tile_q),
      .tile_i     (quantTile),
      .rd_ack_i   (handshake && (rdSel_q == 1'(b))),
      .state_o    (bankState[b]),
      .data_o     (bankData[b])
    );
  end

endmodule

// File: tb/tb_fixed_2d_tile_gather.sv
// Directed self-checking bench for fixed_2d_tile_gather with default parameters.
module tb_fixed_2d_tile_gather;

  localparam int IW = 32;
  localparam int OW = 8;
  localparam int NE = 4;
  localparam int NO = 12;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NE-1:0][IW-1:0] data_in = '0;
  logic                  data_in_valid = 1'b0;
  logic                  data_in_ready;
  logic [NO-1:0][OW-1:0] data_out;
  logic                  data_out_valid;
  logic                  data_out_ready = 1'b0;
  logic                  data_out_last;

  int compared   = 0;
  int mismatched = 0;

  // din indexed by t*4 + r*2 + c; expOut indexed by output word r*6 + t*2 + c.
  typedef struct {
    logic [31:0] din    [12];
    logic [7:0]  expOut [12];
    logic        expLast;
  } vec_t;

  vec_t vecs [3];

  fixed_2d_tile_gather dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .data_out_last  (data_out_last)
  );

  // 10-unit clock.
  always #5 clk = ~clk;

  // Hard stop in case something wedges outside the bounded loops.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NE-1:0][IW-1:0] tileOf(input logic [31:0] w);
    logic [NE-1:0][IW-1:0] r;
    for (int i = 0; i < NE; i++) r[i] = w;
    return r;
  endfunction

  function automatic logic [NO-1:0][OW-1:0] blockOf(input logic [7:0] b);
    logic [NO-1:0][OW-1:0] r;
    for (int i = 0; i < NO; i++) r[i] = b;
    return r;
  endfunction

  // Present one tile and wait (bounded) until it is accepted.
  task automatic applyStimulus(input logic [NE-1:0][IW-1:0] tile);
    bit done;
    done          = 1'b0;
    data_in       = tile;
    data_in_valid = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      if (data_in_ready) done = 1'b1;
      tick();
    end
    data_in_valid = 1'b0;
    if (!done) checkOutput("acceptTimeout", 128'(done), 128'(1));
  endtask

  task automatic pulseReset();
    data_in_valid  = 1'b0;
    data_out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    logic [NE-1:0][IW-1:0] tile;
    logic [NO-1:0][OW-1:0] expv;
    int sent;
    int beats;

    vecs[0].din    = '{32'h00, 32'h10, 32'h20, 32'h30,
                       32'h40, 32'h50, 32'h60, 32'h70,
                       32'h80, 32'h90, 32'hA0, 32'hB0};
    vecs[0].expOut = '{8'h00, 8'h01, 8'h04, 8'h05, 8'h08, 8'h09,
                       8'h02, 8'h03, 8'h06, 8'h07, 8'h0A, 8'h0B};
    vecs[0].expLast = 1'b0;

    vecs[1].din    = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h0000000F,
                       32'hFFFFFF00, 32'h00000800, 32'h000007F0, 32'hFFFFF800,
                       32'hFFFFF7F0, 32'h00000010, 32'hFFFFFFF0, 32'hFFFFFFEF};
    vecs[1].expOut = '{8'h7F, 8'h80, 8'hF0, 8'h7F, 8'h80, 8'h01,
                       8'hFF, 8'h00, 8'h7F, 8'h80, 8'hFF, 8'hFE};
    vecs[1].expLast = 1'b1;

    vecs[2].din    = '{32'h00000100, 32'h00000123, 32'hFFFFFEDD, 32'h00000000,
                       32'h12345678, 32'hEDCBA988, 32'h0000001F, 32'hFFFFFFE1,
                       32'h000007FF, 32'hFFFFF80F, 32'h00000050, 32'hFFFFFFB0};
    vecs[2].expOut = '{8'h10, 8'h12, 8'h7F, 8'h80, 8'h7F, 8'h80,
                       8'hED, 8'h00, 8'h01, 8'hFE, 8'h05, 8'hFB};
    vecs[2].expLast = 1'b0;

    // Reset state, sampled while reset is asserted.
    #2 rst = 1'b1;
    #1;
    checkOutput("rstValid", 128'(data_out_valid), 128'(0));
    checkOutput("rstReady", 128'(data_in_ready), 128'(1));
    checkOutput("rstLast",  128'(data_out_last), 128'(0));
    checkOutput("rstData",  128'(data_out), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Table: placement, saturation and mixed requantisation blocks.
    data_out_ready = 1'b1;
    for (int v = 0; v < 3; v++) begin
      for (int t = 0; t < 3; t++) begin
        for (int e = 0; e < NE; e++) tile[e] = vecs[v].din[t*4 + e];
        applyStimulus(tile);
        if (t == 1) checkOutput($sformatf("vec%0dValidEarly", v), 128'(data_out_valid), 128'(0));
      end
      for (int i = 0; i < NO; i++) expv[i] = vecs[v].expOut[i];
      checkOutput($sformatf("vec%0dValid", v), 128'(data_out_valid), 128'(1));
      checkOutput($sformatf("vec%0dData", v),  128'(data_out), 128'(expv));
      checkOutput($sformatf("vec%0dLast", v),  128'(data_out_last), 128'(vecs[v].expLast));
    end
    tick();

    // Backpressure: both banks fill, seventh tile is held.
    pulseReset();
    for (int t = 0; t < 3; t++) applyStimulus(tileOf(32'h00000030));
    for (int t = 0; t < 3; t++) applyStimulus(tileOf(32'hFFFFFFC0));
    checkOutput("bpReadyLow", 128'(data_in_ready), 128'(0));
    data_in       = tileOf(32'h00000050);
    data_in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("bpHeld", 128'(data_in_ready), 128'(0));
    end
    checkOutput("bpDataA", 128'(data_out), 128'(blockOf(8'h03)));
    checkOutput("bpLastA", 128'(data_out_last), 128'(0));
    data_out_ready = 1'b1;
    tick();
    data_out_ready = 1'b0;
    checkOutput("bpReadyBack", 128'(data_in_ready), 128'(1));
    checkOutput("bpValidB",    128'(data_out_valid), 128'(1));
    checkOutput("bpDataB",     128'(data_out), 128'(blockOf(8'hFC)));
    checkOutput("bpLastB",     128'(data_out_last), 128'(1));
    tick();
    data_in_valid = 1'b0;
    checkOutput("bpSeventhIn", 128'(data_in_ready), 128'(1));

    // Streaming: twelve back-to-back tiles with the sink always ready.
    pulseReset();
    data_out_ready = 1'b1;
    sent  = 0;
    beats = 0;
    data_in       = tileOf(32'h00000010);
    data_in_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && beats < 4; cyc++) begin
      if (data_out_valid) begin
        checkOutput($sformatf("streamData%0d", beats), 128'(data_out), 128'(blockOf(8'(beats + 1))));
        checkOutput($sformatf("streamLast%0d", beats), 128'(data_out_last), 128'(beats == 1 || beats == 3));
        beats++;
      end
      if (sent < 12) begin
        checkOutput("streamReady", 128'(data_in_ready), 128'(1));
        if (data_in_ready) sent++;
      end
      tick();
      if (sent >= 12) data_in_valid = 1'b0;
      else data_in = tileOf(32'((sent / 3 + 1) << 4));
    end
    data_in_valid = 1'b0;
    checkOutput("streamBeats", 128'(beats), 128'(4));
    checkOutput("streamTiles", 128'(sent), 128'(12));

    // Reset mid-fill discards the partial block.
    pulseReset();
    data_out_ready = 1'b1;
    applyStimulus(tileOf(32'h00000070));
    applyStimulus(tileOf(32'h00000070));
    rst = 1'b1;
    #1;
    checkOutput("midRstValid", 128'(data_out_valid), 128'(0));
    checkOutput("midRstReady", 128'(data_in_ready), 128'(1));
    @(negedge clk);
    rst = 1'b0;
    tick();
    applyStimulus(tileOf(32'h00000020));
    applyStimulus(tileOf(32'h00000020));
    checkOutput("midRstNotYet", 128'(data_out_valid), 128'(0));
    applyStimulus(tileOf(32'h00000020));
    checkOutput("midRstValid2", 128'(data_out_valid), 128'(1));
    checkOutput("midRstData",   128'(data_out), 128'(blockOf(8'h02)));
    checkOutput("midRstLast",   128'(data_out_last), 128'(0));
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
